regfile_scoreboard: RTL and testbench

Parametrised successor to the single-cycle 2-read/1-write register file, for the 5-stage pipeline. Adds:
- N combinational read ports with write-to-read bypass.
- A hardwired zero register.
- A per-register busy scoreboard. ID uses it to detect RAW hazards against long-latency producers (loads) and raise stall.

Sits in ID; the write port is driven by the MEM/WB stage.

---
 rtl/regfile_scoreboard_pkg.sv | 34 +++
 rtl/regfile_scoreboard_if.sv | 37 +++
 rtl/regfile_scoreboard_sb_core.sv | 67 ++++++
 rtl/regfile_scoreboard.sv | 83 ++++++++
 tb/tb_regfile_scoreboard.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/regfile_scoreboard_pkg.sv
// Shared definitions for the register file / scoreboard slice: default
// geometry, width helper and address-validity rule.
package regfile_scoreboard_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 32;
    localparam int NRD_DEF    = 2;

    // Per-register scoreboard action chosen each cycle
    typedef enum logic [1:0] {
        SB_HOLD  = 2'd0,
        SB_SET   = 2'd1,
        SB_CLR   = 2'd2,
        SB_FLUSH = 2'd3
    } sb_op_e;

    // Ceiling log2, never narrower than one bit
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    // An address names real storage only below nregs, and never the
    // hardwired zero register.
    function automatic logic addr_ok(input logic [31:0] a, input int nregs,
                                     input logic zero_reg);
        return (a < 32'(nregs)) && !(zero_reg && (a == 32'd0));
    endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Bundle of read, writeback and scoreboard signals between ID and the
// register file.
interface regfile_scoreboard_if
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF,
    parameter int NRD    = NRD_DEF
);
    localparam int AW = clog2(NREGS);
    localparam int CW = clog2(NREGS + 1);

    logic [NRD-1:0]        rd_en;
    logic [NRD*AW-1:0]     rd_addr;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;
    logic                  stall;
    logic                  wr_en;
    logic [AW-1:0]         wr_addr;
    logic [DATA_W-1:0]     wr_data;
    logic                  sb_set;
    logic [AW-1:0]         sb_addr;
    logic                  flush;
    logic [NREGS-1:0]      busy_vec;
    logic [CW-1:0]         busy_cnt;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush,
        input  rd_data, rd_busy, stall, busy_vec, busy_cnt
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, flush,
        output rd_data, rd_busy, stall, busy_vec, busy_cnt
    );

endinterface

// File: rtl/regfile_scoreboard_sb_core.sv
// Busy scoreboard: one bit per register plus a registered population count.
// Priority per register: flush, then set (new producer), then clear.
module regfile_scoreboard_sb_core
    import regfile_scoreboard_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2(NREGS),
    parameter int CW       = clog2(NREGS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_i,
    input  logic [AW-1:0]    set_addr_i,
    input  logic             clr_i,
    input  logic [AW-1:0]    clr_addr_i,
    input  logic             flush_i,
    output logic [NREGS-1:0] busy_vec_o,
    output logic [CW-1:0]    busy_cnt_o
);

    logic [NREGS-1:0] busy_q, busy_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             set_ok, clr_ok;
    sb_op_e           op_d [NREGS];

    assign set_ok = set_i && addr_ok(32'(set_addr_i), NREGS, ZERO_REG != 0);
    assign clr_ok = clr_i && addr_ok(32'(clr_addr_i), NREGS, ZERO_REG != 0);

    // Choose each register's action and derive the next busy bits
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREGS; r++) begin
            op_d[r] = SB_HOLD;
            if (flush_i)                                op_d[r] = SB_FLUSH;
            else if (set_ok && set_addr_i == AW'(r))    op_d[r] = SB_SET;
            else if (clr_ok && clr_addr_i == AW'(r))    op_d[r] = SB_CLR;
            case (op_d[r])
                SB_FLUSH: busy_d[r] = 1'b0;
                SB_SET:   busy_d[r] = 1'b1;
                SB_CLR:   busy_d[r] = 1'b0;
                default:  busy_d[r] = busy_q[r];
            endcase
        end
    end

    // Count is computed from the next state so it tracks busy_q exactly
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < NREGS; r++) cnt_d = cnt_d + CW'(busy_d[r]);
    end

    // Scoreboard state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_vec_o = busy_q;
    assign busy_cnt_o = cnt_q;

endmodule

// File: rtl/regfile_scoreboard.sv
// ID-stage register file: NRD combinational read ports with writeback
// bypass, optional hardwired zero register, and a busy scoreboard that
// raises stall on RAW hazards against pending long-latency producers.
module regfile_scoreboard
    import regfile_scoreboard_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NREGS      = NREGS_DEF,
    parameter int NRD        = NRD_DEF,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1,
    parameter int INIT_INDEX = 1
) (
    input logic                 clk,
    input logic                 rst,
    regfile_scoreboard_if.slave bus
);

    localparam int AW = clog2(NREGS);
    localparam int CW = clog2(NREGS + 1);

    logic [DATA_W-1:0]     regs_q [NREGS];
    logic                  wr_ok;
    logic [NREGS-1:0]      busy_vec;
    logic [CW-1:0]         busy_cnt;
    logic [NRD*DATA_W-1:0] rd_data;
    logic [NRD-1:0]        rd_busy;

    assign wr_ok = bus.wr_en && addr_ok(32'(bus.wr_addr), NREGS, ZERO_REG != 0);

    // Architectural storage; reset optionally seeds reg[i] = i
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++)
                regs_q[i] <= (INIT_INDEX != 0) ? DATA_W'(i) : '0;
        end else if (wr_ok) begin
            regs_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    regfile_scoreboard_sb_core #(
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW),
        .CW       (CW)
    ) u_sb (
        .clk        (clk),
        .rst        (rst),
        .set_i      (bus.sb_set),
        .set_addr_i (bus.sb_addr),
        .clr_i      (bus.wr_en),
        .clr_addr_i (bus.wr_addr),
        .flush_i    (bus.flush),
        .busy_vec_o (busy_vec),
        .busy_cnt_o (busy_cnt)
    );

    // Read ports: invalid address reads zero, then bypass, then storage.
    // A bypassed writeback also hides the busy bit it is about to clear.
    always_comb begin
        logic [AW-1:0] a;
        logic          hit;
        rd_data = '0;
        rd_busy = '0;
        a       = '0;
        hit     = 1'b0;
        for (int p = 0; p < NRD; p++) begin
            a   = bus.rd_addr[p*AW +: AW];
            hit = (BYPASS != 0) && bus.wr_en && (bus.wr_addr == a);
            if (addr_ok(32'(a), NREGS, ZERO_REG != 0)) begin
                rd_data[p*DATA_W +: DATA_W] = hit ? bus.wr_data : regs_q[a];
                rd_busy[p] = bus.rd_en[p] && busy_vec[a] && !hit;
            end
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.stall    = |rd_busy;
    assign bus.busy_vec = busy_vec;
    assign bus.busy_cnt = busy_cnt;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench: directed table for the listed corner cases, then random traffic
// against an array-based model on three configurations (default, no bypass,
// 20 registers / no zero reg / zero init / 3 read ports).
module tb_regfile_scoreboard;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [1:0]  en_a = '0;
    logic [9:0]  addr_a = '0;
    logic [2:0]  en_c = '0;
    logic [14:0] addr_c = '0;
    logic        we = 1'b0, ss = 1'b0, fl = 1'b0;
    logic [4:0]  wa = '0, sa = '0;
    logic [31:0] wd = '0;

    regfile_scoreboard_if ifa ();
    regfile_scoreboard_if ifb ();
    regfile_scoreboard_if #(.NREGS(20), .NRD(3)) ifc ();

    assign ifa.rd_en = en_a;  assign ifa.rd_addr = addr_a;
    assign ifb.rd_en = en_a;  assign ifb.rd_addr = addr_a;
    assign ifc.rd_en = en_c;  assign ifc.rd_addr = addr_c;
    assign ifa.wr_en = we; assign ifa.wr_addr = wa; assign ifa.wr_data = wd;
    assign ifb.wr_en = we; assign ifb.wr_addr = wa; assign ifb.wr_data = wd;
    assign ifc.wr_en = we; assign ifc.wr_addr = wa; assign ifc.wr_data = wd;
    assign ifa.sb_set = ss; assign ifa.sb_addr = sa; assign ifa.flush = fl;
    assign ifb.sb_set = ss; assign ifb.sb_addr = sa; assign ifb.flush = fl;
    assign ifc.sb_set = ss; assign ifc.sb_addr = sa; assign ifc.flush = fl;

    regfile_scoreboard dut_a (.clk(clk), .rst(rst), .bus(ifa));
    regfile_scoreboard #(.BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
    regfile_scoreboard #(.NREGS(20), .NRD(3), .ZERO_REG(0), .INIT_INDEX(0))
        dut_c (.clk(clk), .rst(rst), .bus(ifc));

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          NR [3] = '{32, 32, 20};
    bit          ZR [3] = '{1, 1, 0};
    bit          BP [3] = '{1, 0, 1};
    bit          II [3] = '{1, 1, 0};
    int          NP [3] = '{2, 2, 3};
    int unsigned mreg  [3][32];
    bit          mbusy [3][32];

    function automatic bit mvalid(input int k, input int a);
        return (a < NR[k]) && !(ZR[k] && a == 0);
    endfunction

    task automatic mupdate();
        for (int k = 0; k < 3; k++) begin
            if (!rst) begin
                for (int r = 0; r < 32; r++) begin
                    mreg[k][r]  = II[k] ? r : 0;
                    mbusy[k][r] = 0;
                end
            end else begin
                if (we && mvalid(k, wa)) mreg[k][wa] = wd;
                if (fl) begin
                    for (int r = 0; r < 32; r++) mbusy[k][r] = 0;
                end else begin
                    if (we && mvalid(k, wa)) mbusy[k][wa] = 0;
                    if (ss && mvalid(k, sa)) mbusy[k][sa] = 1;
                end
            end
        end
    endtask

    task automatic mcheck(input int cyc);
        for (int k = 0; k < 3; k++) begin
            bit          st_e, st_a;
            logic [31:0] vec_e, vec_a;
            int          cnt_e, cnt_a;
            st_e = 0; vec_e = '0; cnt_e = 0;
            for (int p = 0; p < NP[k]; p++) begin
                int          a;
                bit          en, hit, ok, be, ba;
                int unsigned de;
                logic [31:0] da;
                a   = (k < 2) ? int'(addr_a[p*5 +: 5]) : int'(addr_c[p*5 +: 5]);
                en  = (k < 2) ? en_a[p] : en_c[p];
                ok  = mvalid(k, a);
                hit = BP[k] && we && (int'(wa) == a);
                de  = !ok ? 0 : (hit ? wd : mreg[k][a]);
                be  = en && ok && mbusy[k][a] && !hit;
                st_e |= be;
                case (k)
                    0:       begin da = ifa.rd_data[p*32 +: 32]; ba = ifa.rd_busy[p]; end
                    1:       begin da = ifb.rd_data[p*32 +: 32]; ba = ifb.rd_busy[p]; end
                    default: begin da = ifc.rd_data[p*32 +: 32]; ba = ifc.rd_busy[p]; end
                endcase
                chk($sformatf("rnd c%0d dut%0d rd_data[%0d]", cyc, k, p), 64'(da), 64'(de));
                chk($sformatf("rnd c%0d dut%0d rd_busy[%0d]", cyc, k, p), 64'(ba), 64'(be));
            end
            for (int r = 0; r < NR[k]; r++) begin
                vec_e[r] = mbusy[k][r];
                cnt_e += int'(mbusy[k][r]);
            end
            case (k)
                0:       begin st_a = ifa.stall; vec_a = ifa.busy_vec; cnt_a = int'(ifa.busy_cnt); end
                1:       begin st_a = ifb.stall; vec_a = ifb.busy_vec; cnt_a = int'(ifb.busy_cnt); end
                default: begin st_a = ifc.stall; vec_a = 32'(ifc.busy_vec); cnt_a = int'(ifc.busy_cnt); end
            endcase
            chk($sformatf("rnd c%0d dut%0d stall", cyc, k), 64'(st_a), 64'(st_e));
            chk($sformatf("rnd c%0d dut%0d busy_vec", cyc, k), 64'(vec_a), 64'(vec_e));
            chk($sformatf("rnd c%0d dut%0d busy_cnt", cyc, k), 64'(cnt_a), 64'(cnt_e));
        end
    endtask

    task automatic finish_cycle();
        @(posedge clk);
        mupdate();
        @(negedge clk);
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        bit rst; bit [1:0] en; bit [4:0] a0, a1; bit we; bit [4:0] wa; bit [31:0] wd;
        bit ss; bit [4:0] sa; bit fl;
        bit chk; bit [31:0] d0, d1; bit [1:0] bz; bit st; bit [31:0] vec; bit [5:0] cnt;
        bit [31:0] d0b; bit stb;
    } vec_t;

    vec_t vt [17];

    function automatic logic [4:0] raddr();
        return ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
    endfunction

    initial begin
        //        rst en a0 a1 we wa wd        ss sa fl  chk d0      d1      bz st vec    cnt d0b     stb
        vt[0]  = '{0, 0, 0, 0, 0, 0, 0,        0, 0, 0,  0, 0,      0,      0, 0, 0,     0, 0,      0};
        vt[1]  = '{1, 0, 5, 31,0, 0, 0,        0, 0, 0,  1, 5,      31,     0, 0, 0,     0, 5,      0};
        vt[2]  = '{1, 0, 0, 0, 1, 0, 'hDEAD,   1, 0, 0,  1, 0,      0,      0, 0, 0,     0, 0,      0};
        vt[3]  = '{1, 0, 0, 0, 0, 0, 0,        0, 0, 0,  1, 0,      0,      0, 0, 0,     0, 0,      0};
        vt[4]  = '{1, 0, 7, 7, 1, 7, 'h1234,   0, 0, 0,  1, 'h1234, 'h1234, 0, 0, 0,     0, 7,      0};
        vt[5]  = '{1, 2, 7, 9, 0, 0, 0,        1, 9, 0,  1, 'h1234, 9,      0, 0, 0,     0, 'h1234, 0};
        vt[6]  = '{1, 2, 7, 9, 0, 0, 0,        0, 0, 0,  1, 'h1234, 9,      2, 1, 'h200, 1, 'h1234, 1};
        vt[7]  = '{1, 2, 7, 9, 1, 9, 55,       0, 0, 0,  1, 'h1234, 55,     0, 0, 'h200, 1, 'h1234, 1};
        vt[8]  = '{1, 2, 7, 9, 0, 0, 0,        0, 0, 0,  1, 'h1234, 55,     0, 0, 0,     0, 'h1234, 0};
        vt[9]  = '{1, 0, 4, 4, 0, 0, 0,        1, 4, 0,  1, 4,      4,      0, 0, 0,     0, 4,      0};
        vt[10] = '{1, 1, 4, 4, 1, 4, 'h44,     1, 4, 0,  1, 'h44,   'h44,   0, 0, 'h10,  1, 4,      1};
        vt[11] = '{1, 1, 4, 4, 0, 0, 0,        0, 0, 0,  1, 'h44,   'h44,   1, 1, 'h10,  1, 'h44,   1};
        vt[12] = '{1, 0, 4, 4, 0, 0, 0,        1, 3, 0,  1, 'h44,   'h44,   0, 0, 'h10,  1, 'h44,   0};
        vt[13] = '{1, 0, 4, 4, 0, 0, 0,        1, 5, 0,  1, 'h44,   'h44,   0, 0, 'h18,  2, 'h44,   0};
        vt[14] = '{1, 0, 4, 4, 0, 0, 0,        1, 6, 1,  1, 'h44,   'h44,   0, 0, 'h38,  3, 'h44,   0};
        vt[15] = '{0, 0, 5, 7, 1, 2, 99,       1, 8, 0,  1, 5,      'h1234, 0, 0, 0,     0, 5,      0};
        vt[16] = '{1, 0, 2, 7, 0, 0, 0,        0, 0, 0,  1, 2,      7,      0, 0, 0,     0, 2,      0};

        for (int i = 0; i < 17; i++) begin
            rst = vt[i].rst; en_a = vt[i].en; addr_a = {vt[i].a1, vt[i].a0};
            we = vt[i].we; wa = vt[i].wa; wd = vt[i].wd;
            ss = vt[i].ss; sa = vt[i].sa; fl = vt[i].fl;
            en_c = '0; addr_c = '0;
            #2;
            if (vt[i].chk) begin
                chk($sformatf("row%0d rd_data0", i), 64'(ifa.rd_data[31:0]), 64'(vt[i].d0));
                chk($sformatf("row%0d rd_data1", i), 64'(ifa.rd_data[63:32]), 64'(vt[i].d1));
                chk($sformatf("row%0d rd_busy", i), 64'(ifa.rd_busy), 64'(vt[i].bz));
                chk($sformatf("row%0d stall", i), 64'(ifa.stall), 64'(vt[i].st));
                chk($sformatf("row%0d busy_vec", i), 64'(ifa.busy_vec), 64'(vt[i].vec));
                chk($sformatf("row%0d busy_cnt", i), 64'(ifa.busy_cnt), 64'(vt[i].cnt));
                chk($sformatf("row%0d nobyp rd_data0", i), 64'(ifb.rd_data[31:0]), 64'(vt[i].d0b));
                chk($sformatf("row%0d nobyp stall", i), 64'(ifb.stall), 64'(vt[i].stb));
            end
            finish_cycle();
        end

        // Random traffic, biased toward a few low registers to force collisions
        for (int c = 0; c < 800; c++) begin
            rst    = ($urandom_range(0, 63) != 0);
            en_a   = 2'($urandom);
            addr_a = {raddr(), raddr()};
            en_c   = 3'($urandom);
            addr_c = {raddr(), raddr(), raddr()};
            we     = ($urandom_range(0, 1) == 1);
            wa     = raddr();
            wd     = $urandom;
            ss     = ($urandom_range(0, 2) == 0);
            sa     = raddr();
            fl     = ($urandom_range(0, 24) == 0);
            #2;
            mcheck(c);
            finish_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
